// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU (priority) and a DMA/debug-loader master.
// Optional performance counters are enabled with the DMEM_ARB_PERF_EN macro.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_funct3,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [2:0]  dma_funct3,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_dma_cnt
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        ARB_CPU,
        ARB_DMA_LOCK
    } arb_state_t;

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic          starve_full;
    logic          burst_full;
    logic          dma_win;

    always_comb begin
        starve_full = (starve_cnt == SW'(STARVE_LIMIT));
        burst_full  = (burst_cnt == BW'(BURST_MAX));
        dma_win     = 1'b0;
        case (state)
            ARB_CPU:      dma_win = dma_req & (~cpu_req | starve_full);
            ARB_DMA_LOCK: dma_win = dma_req & ~(cpu_req & burst_full);
            default:      dma_win = 1'b0;
        endcase
    end

    // A stalled CPU never reaches the port: the mux follows dma_win alone.
    assign dma_gnt    = dma_win;
    assign cpu_stall  = cpu_req & dma_win;
    assign mem_we     = dma_win ? dma_we : (cpu_req & cpu_we);
    assign mem_addr   = dma_win ? dma_addr : cpu_addr;
    assign mem_wdata  = dma_win ? dma_wdata : cpu_wdata;
    assign mem_funct3 = dma_win ? dma_funct3 : cpu_funct3;
    assign cpu_rdata  = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_CPU;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_win & ~dma_we;
            if (dma_win & ~dma_we) begin
                dma_rdata <= mem_rdata;
            end

            if (dma_req & ~dma_win) begin
                if (!starve_full) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end

            case (state)
                ARB_CPU: begin
                    if (dma_win & dma_lock) begin
                        state     <= ARB_DMA_LOCK;
                        burst_cnt <= BW'(1);
                    end
                end
                ARB_DMA_LOCK: begin
                    // Leave on abandon, on the yielded CPU cycle, or on an unlocked grant.
                    if (!dma_req || (cpu_req && burst_full) || (dma_win && !dma_lock)) begin
                        state     <= ARB_CPU;
                        burst_cnt <= '0;
                    end else if (dma_win && !burst_full) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                default: begin
                    state     <= ARB_CPU;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_dma_cnt   <= '0;
        end else begin
            if (cpu_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (dma_gnt) begin
                perf_dma_cnt <= perf_dma_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-addressed dmem model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_lock;
    logic [31:0] dma_addr, dma_wdata;
    logic [2:0]  dma_funct3;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_dma_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dmem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = dmem[mem_addr[7:2]];

    dmem_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_funct3(dma_funct3), .dma_lock(dma_lock),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_funct3 = 3'b010;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_funct3 = 3'b010;
        dma_lock = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        logic exp_g;
        reset = 1;
        idle_inputs();
        #1;
        chk("rst_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // CPU store, then zero-latency load
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h64; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("cpu_wr_we", 32'(mem_we), 32'd1);
        chk("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        chk("cpu_wr_addr", mem_addr, 32'h64);
        chk("cpu_wr_data", mem_wdata, 32'hDEADBEEF);
        $display("txn cpu_write addr=%h data=%h", cpu_addr, cpu_wdata);
        @(negedge clk);
        cpu_we = 0;
        #1;
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_rd_we", 32'(mem_we), 32'd0);
        $display("txn cpu_read addr=%h data=%h", cpu_addr, cpu_rdata);

        // no requester: no write even with cpu_we high, address mirrors CPU
        @(negedge clk);
        cpu_req = 0; cpu_we = 1; cpu_addr = 32'h70;
        #1;
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_addr", mem_addr, 32'h70);
        $display("txn idle");

        // DMA read with registered return
        @(negedge clk);
        cpu_we = 0;
        dma_req = 1; dma_we = 0; dma_addr = 32'h64;
        #1;
        chk("dma_rd_gnt", 32'(dma_gnt), 32'd1);
        chk("dma_rd_stall", 32'(cpu_stall), 32'd0);
        chk("dma_rd_addr", mem_addr, 32'h64);
        @(negedge clk);
        dma_req = 0;
        #1;
        chk("dma_rd_rvalid", 32'(dma_rvalid), 32'd1);
        chk("dma_rd_rdata", dma_rdata, 32'hDEADBEEF);
        $display("txn dma_read addr=64 data=%h", dma_rdata);
        @(negedge clk);
        #1;
        chk("dma_rvalid_drop", 32'(dma_rvalid), 32'd0);

        // DMA write, CPU reads it back
        dma_req = 1; dma_we = 1; dma_addr = 32'h68; dma_wdata = 32'h12345678;
        #1;
        chk("dma_wr_we", 32'(mem_we), 32'd1);
        chk("dma_wr_data", mem_wdata, 32'h12345678);
        $display("txn dma_write addr=68 data=12345678");
        @(negedge clk);
        dma_req = 0; dma_we = 0;
        cpu_req = 1; cpu_addr = 32'h68;
        #1;
        chk("dma_wr_rb", cpu_rdata, 32'h12345678);
        chk("dma_wr_norvalid", 32'(dma_rvalid), 32'd0);
        $display("txn cpu_read addr=68 data=%h", cpu_rdata);

        // starvation: CPU store vs DMA read, every fifth cycle forced to DMA
        pulse_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h64; cpu_wdata = 32'hDEADBEEF;
        dma_req = 1; dma_we = 0; dma_addr = 32'h68; dma_lock = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_g = (i % 5 == 4);
            chk($sformatf("starve_gnt[%0d]", i), 32'(dma_gnt), 32'(exp_g));
            chk($sformatf("starve_stall[%0d]", i), 32'(cpu_stall), 32'(exp_g));
            chk($sformatf("starve_we[%0d]", i), 32'(mem_we), 32'(!exp_g));
            chk($sformatf("starve_addr[%0d]", i), mem_addr, exp_g ? 32'h68 : 32'h64);
            $display("txn starve cycle=%0d gnt=%0b stall=%0b", i, dma_gnt, cpu_stall);
            @(negedge clk);
        end
        cpu_req = 0; cpu_we = 0; dma_req = 0;
        #1;
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'd4);
        chk("perf_dma", perf_dma_cnt, 32'd4);
`endif

        // locked burst against a CPU that requests throughout
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h64;
        dma_req = 1; dma_we = 0; dma_addr = 32'h68; dma_lock = 1;
        for (int i = 0; i < 19; i++) begin
            #1;
            exp_g = (i >= 4 && i <= 11) || (i >= 16);
            chk($sformatf("burst_gnt[%0d]", i), 32'(dma_gnt), 32'(exp_g));
            chk($sformatf("burst_stall[%0d]", i), 32'(cpu_stall), 32'(exp_g));
            chk($sformatf("burst_addr[%0d]", i), mem_addr, exp_g ? 32'h68 : 32'h64);
            $display("txn burst cycle=%0d gnt=%0b stall=%0b", i, dma_gnt, cpu_stall);
            if (i < 18) @(negedge clk);
        end

        // asynchronous reset in the third cycle of the second burst
        #2;
        reset = 1;
        dma_req = 0;
        #1;
        chk("midrst_gnt", 32'(dma_gnt), 32'd0);
        chk("midrst_stall", 32'(cpu_stall), 32'd0);
        chk("midrst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("midrst_rdata", dma_rdata, 32'd0);
        $display("txn reset_mid_burst");
        @(negedge clk);
        reset = 0;
        dma_req = 1; dma_lock = 0;
        #1;
        chk("postrst_gnt", 32'(dma_gnt), 32'd0);
        chk("postrst_stall", 32'(cpu_stall), 32'd0);
        chk("postrst_rvalid", 32'(dma_rvalid), 32'd0);
        $display("txn post_reset gnt=%0b", dma_gnt);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
